// File: rtl/ldtu_pkg.sv
// LiTe-DTU shared constants: sample widths, gain encoding,
// default timing parameters and a small width helper.
package ldtu_pkg;

  localparam int NDATA       = 12;
  localparam int NBAS        = 6;
  localparam int LATENCY     = 3;
  localparam int ORBIT_BLANK = 8;
  localparam int CNT_W       = 16;

  localparam logic GAIN_X10 = 1'b0;
  localparam logic GAIN_X1  = 1'b1;

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldtu_orbit_filter.sv
// Orbit edge detector with a blanking window and a saturating
// count of accepted BC0 pulses.
module ldtu_orbit_filter
  import ldtu_pkg::*;
#(
  parameter int ORBIT_BLANK = ldtu_pkg::ORBIT_BLANK,
  parameter int CNT_W       = ldtu_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             orbit_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] orb_count_o
);

  localparam int BW = cnt_bits(ORBIT_BLANK);

  logic             prev_q;
  logic [BW-1:0]    blank_q, blank_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Edges inside the window are dropped and never reload it.
  always_comb begin
    pulse_o = orbit_i && !prev_q && (blank_q == '0);
    blank_d = blank_q;
    if (pulse_o)
      blank_d = BW'(ORBIT_BLANK - 1);
    else if (blank_q != '0)
      blank_d = blank_q - BW'(1);
    cnt_d = cnt_q;
    if (pulse_o && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      blank_q <= '0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= orbit_i;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
    end
  end

  assign orb_count_o = cnt_q;

endmodule

// File: rtl/ldtu_baseline_flagger.sv
// Baseline/signal classifier, BC0 pulse shaper and alignment
// delay line feeding the LiTe-DTU encoder FSM.
module ldtu_baseline_flagger
  import ldtu_pkg::*;
#(
  parameter int NDATA       = ldtu_pkg::NDATA,
  parameter int NBAS        = ldtu_pkg::NBAS,
  parameter int LATENCY     = ldtu_pkg::LATENCY,
  parameter int ORBIT_BLANK = ldtu_pkg::ORBIT_BLANK,
  parameter int CNT_W       = ldtu_pkg::CNT_W
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [NDATA-1:0] DATA_in,
  input  logic             gain_sel,
  input  logic             Orbit_in,
  input  logic             fallback,
  output logic [NDATA:0]   DATA_out,
  output logic             baseline_flag,
  output logic             Orbit,
  output logic [CNT_W-1:0] sig_count,
  output logic [CNT_W-1:0] orb_count
);

  // Tuple layout: {gain, data, flag, pulse}
  localparam int TW = NDATA + 3;

  logic [NDATA-1:0] d0_q;
  logic             g0_q, o0_q, fb0_q;
  logic             flag_d, pulse;
  logic [CNT_W-1:0] sig_q, sig_d;
  logic [TW-1:0]    pipe_q [1:LATENCY-1];

  always_comb begin
    flag_d = (g0_q == GAIN_X10)
          && (d0_q[NDATA-1:NBAS] == '0)
          && !fb0_q;
    sig_d = sig_q;
    if (!flag_d && !fb0_q && (sig_q != '1))
      sig_d = sig_q + CNT_W'(1);
  end

  ldtu_orbit_filter #(
    .ORBIT_BLANK (ORBIT_BLANK),
    .CNT_W       (CNT_W)
  ) u_orbit (
    .clk_i       (CLK),
    .rst_i       (rst),
    .orbit_i     (o0_q),
    .pulse_o     (pulse),
    .orb_count_o (orb_count)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      d0_q  <= '0;
      g0_q  <= 1'b0;
      o0_q  <= 1'b0;
      fb0_q <= 1'b0;
      sig_q <= '0;
      for (int k = 1; k < LATENCY; k++)
        pipe_q[k] <= '0;
    end else begin
      d0_q      <= DATA_in;
      g0_q      <= gain_sel;
      o0_q      <= Orbit_in;
      fb0_q     <= fallback;
      sig_q     <= sig_d;
      pipe_q[1] <= {g0_q, d0_q, flag_d, pulse};
      for (int k = 2; k < LATENCY; k++)
        pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign DATA_out      = pipe_q[LATENCY-1][TW-1:2];
  assign baseline_flag = pipe_q[LATENCY-1][1];
  assign Orbit         = pipe_q[LATENCY-1][0];
  assign sig_count     = sig_q;

endmodule

// File: tb/tb_ldtu_baseline_flagger.sv
// Scoreboard bench for ldtu_baseline_flagger: a reference model
// predicts each output tuple, which is popped LATENCY cycles later.
module tb_ldtu_baseline_flagger;

  localparam int NDATA = 12;
  localparam int NBAS  = 6;
  localparam int LAT   = 3;
  localparam int OB    = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic             CLK = 1'b0;
  logic             rst = 1'b0;
  logic [NDATA-1:0] DATA_in = '0;
  logic             gain_sel = 1'b0;
  logic             Orbit_in = 1'b0;
  logic             fallback = 1'b0;
  logic [NDATA:0]   DATA_out;
  logic             baseline_flag;
  logic             Orbit;
  logic [CW-1:0]    sig_count;
  logic [CW-1:0]    orb_count;

  ldtu_baseline_flagger #(
    .NDATA       (NDATA),
    .NBAS        (NBAS),
    .LATENCY     (LAT),
    .ORBIT_BLANK (OB),
    .CNT_W       (CW)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .DATA_in       (DATA_in),
    .gain_sel      (gain_sel),
    .Orbit_in      (Orbit_in),
    .fallback      (fallback),
    .DATA_out      (DATA_out),
    .baseline_flag (baseline_flag),
    .Orbit         (Orbit),
    .sig_count     (sig_count),
    .orb_count     (orb_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NDATA:0] d;
    logic           f;
    logic           o;
    logic           si;
    logic           oi;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic m_prev = 1'b0;
  int   m_blank = 0;
  int   m_sig = 0;
  int   m_orb = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == LAT) begin
      e = q.pop_front();
      chk("data_out", 32'(DATA_out), 32'(e.d));
      chk("flag", 32'(baseline_flag), 32'(e.f));
      chk("orbit", 32'(Orbit), 32'(e.o));
      if (e.si && m_sig < CMAX) m_sig++;
      if (e.oi && m_orb < CMAX) m_orb++;
    end
  endtask

  function automatic exp_t model(input logic [NDATA-1:0] d,
                                 input logic g, input logic o,
                                 input logic fb);
    exp_t e;
    logic acc;
    logic [NDATA-1:0] hi;
    hi = d >> NBAS;
    acc = o && !m_prev && (m_blank == 0);
    if (acc) m_blank = OB - 1;
    else if (m_blank > 0) m_blank--;
    m_prev = o;
    e.d  = {g, d};
    e.f  = !g && (hi == 0) && !fb;
    e.o  = acc;
    e.si = !e.f && !fb;
    e.oi = acc;
    return e;
  endfunction

  task automatic step(input logic [NDATA-1:0] d, input logic g,
                      input logic o, input logic fb);
    @(negedge CLK);
    pop_check();
    rst      = 1'b0;
    DATA_in  = d;
    gain_sel = g;
    Orbit_in = o;
    fallback = fb;
    q.push_back(model(d, g, o, fb));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    pop_check();
    rst      = 1'b1;
    DATA_in  = 12'h03F;
    gain_sel = 1'b0;
    Orbit_in = 1'b1;
    fallback = 1'b0;
    q.delete();
    m_prev  = 1'b0;
    m_blank = 0;
    m_sig   = 0;
    m_orb   = 0;
    for (int k = 0; k < LAT - 1; k++) q.push_back('0);
    q.push_back(model('0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_sig"}, 32'(sig_count), 32'(m_sig));
    chk({tag, "_orb"}, 32'(orb_count), 32'(m_orb));
  endtask

  initial begin
    do_reset();
    idle(LAT);
    chk_counts("reset");

    step(12'h03F, 1'b0, 1'b0, 1'b0);
    idle(LAT);
    chk_counts("base_3f");

    step(12'h040, 1'b0, 1'b0, 1'b0);
    step(12'h005, 1'b1, 1'b0, 1'b0);
    step(12'h000, 1'b1, 1'b0, 1'b0);
    idle(LAT);
    chk_counts("signal");

    for (int k = 0; k < 5; k++) step(12'h011, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk_counts("orb_level");

    step('0, 1'b0, 1'b1, 1'b0);
    idle(3);
    step('0, 1'b0, 1'b1, 1'b0);
    idle(12);
    chk_counts("orb_blank4");

    step('0, 1'b0, 1'b1, 1'b0);
    idle(7);
    step('0, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk_counts("orb_blank8");

    step(12'h03F, 1'b0, 1'b1, 1'b1);
    step(12'h001, 1'b0, 1'b0, 1'b1);
    step(12'h800, 1'b1, 1'b0, 1'b1);
    idle(10);
    chk_counts("fallback");

    step(12'h003, 1'b0, 1'b1, 1'b0);
    step(12'h004, 1'b0, 1'b1, 1'b0);
    do_reset();
    idle(LAT + 1);
    chk_counts("mid_reset");

    for (int k = 0; k < 60; k++) begin
      logic [NDATA-1:0] d;
      d = ($urandom_range(0, 1) == 1) ? NDATA'($urandom_range(0, 80))
                                      : NDATA'($urandom_range(0, 4095));
      step(d, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end
    idle(10);
    chk_counts("random");

    for (int k = 0; k < 20; k++) step(12'h0FF, 1'b0, 1'b0, 1'b0);
    idle(LAT);
    chk_counts("saturate");
    chk("sig_sat", 32'(sig_count), 32'(CMAX));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ldtu_baseline_flagger.md
Name: ldtu_baseline_flagger

Overview:
Upstream stage of the LiTe-DTU encoder FSM. Per sample it classifies the gain-selected ADC sample as baseline (fits in NBAS bits, gain x10) or signal. It turns the raw orbit input into a single-cycle, blanking-filtered BC0 pulse. It delays data, flag and orbit by a fixed pipeline so all three reach the FSM/encoder cycle-aligned.

Parameters:
NDATA, 12, ADC sample width
NBAS, 6, baseline payload width; sample is baseline iff DATA_in[NDATA-1:NBAS]==0
LATENCY, 3, total input-to-output delay in CLK cycles (min 2)
ORBIT_BLANK, 8, cycles after an accepted orbit edge during which further edges are ignored
CNT_W, 16, width of saturating monitor counters

Ports:
CLK  in  1  LiTe-DTU clock; all logic on posedge
rst  in  1  synchronous, active-high reset
DATA_in  in  NDATA  gain-selected ADC sample, one per cycle
gain_sel  in  1  0 = x10 gain, 1 = x1 gain
Orbit_in  in  1  orbit/BC0 level, synchronous to CLK
fallback  in  1  1 = fallback mode; classification disabled
DATA_out  out  NDATA+1  {gain_sel, DATA_in} delayed LATENCY cycles
baseline_flag  out  1  classification of DATA_out sample
Orbit  out  1  one-cycle BC0 pulse aligned with DATA_out
sig_count  out  CNT_W  saturating count of signal-classified samples
orb_count  out  CNT_W  saturating count of accepted orbit pulses

Behaviour:
- Reset: all outputs 0, pipeline registers 0, previous-orbit register 0, blank counter 0. A reset asserted mid-stream clears everything in the next cycle. Any flag or orbit pulse in flight is discarded.
- Stage 0 (cycle 1): register DATA_in, gain_sel, Orbit_in and fallback.
- Stage 1 (cycle 2):
  - flag = (gain_sel==0) && (DATA[NDATA-1:NBAS]==0) && (fallback==0).
  - Edge detect: edge = Orbit_r && !Orbit_prev.
  - Accept the edge iff blank_cnt==0.
  - On accept: pulse=1, blank_cnt loads ORBIT_BLANK-1. Otherwise blank_cnt decrements to 0 and saturates.
  - A level held high produces exactly one pulse.
  - An edge inside the blanking window is dropped and does not restart the window.
- Stages 2..LATENCY-1: plain shift register of the {data, flag, pulse} tuple. Outputs update every cycle; there is no valid/stall.
- Latency: a sample presented at edge N appears on DATA_out/baseline_flag after edge N+LATENCY. An Orbit_in rise at edge N produces Orbit high for exactly the cycle after edge N+LATENCY.
- Sample boundaries:
  - DATA=2^NBAS-1 with gain 0 is baseline.
  - DATA=2^NBAS with gain 0 is signal.
  - Any gain 1 sample is signal.
- Fallback: the flag is forced 0 from the stage-0 registered value onward. Orbit detection continues unchanged.
- sig_count increments when a sample leaving stage 1 has flag==0 and fallback==0. orb_count increments on each accepted pulse. Both saturate at 2^CNT_W-1 and do not wrap. Only rst clears them.
- Simultaneous orbit edge and blank_cnt reaching 0 in the same cycle: the edge is accepted only if blank_cnt was already 0 before that cycle.

Decomposition:
- Shared package ldtu_pkg: NDATA, NBAS, gain encoding constants (GAIN_X10=0, GAIN_X1=1).
- One natural sub-module: ldtu_orbit_filter (edge detect + blanking counter + orb_count).
- The classifier and delay line stay in the top.

Test Plan:
- Reset then DATA_in=0x03F gain 0 → after LATENCY=3 cycles: baseline_flag=1, DATA_out=0x03F; sig_count=0.
- DATA_in=0x040 gain 0, then 0x005 gain 1 → both flag=0, sig_count=2, DATA_out MSB = gain bit.
- Orbit_in high for 5 cycles → exactly one Orbit pulse, 3 cycles after the rise; orb_count=1.
- Two Orbit_in rises 4 cycles apart (ORBIT_BLANK=8) → one pulse. Rises 8 cycles apart → two pulses.
- fallback=1 with baseline data → flag=0, sig_count unchanged. An orbit during fallback still produces a pulse.
- Assert rst while a flag=1 sample and an orbit pulse are in the pipeline → outputs 0 the next cycle, no pulse emerges. Drive sig_count to saturation (CNT_W=4) → holds at 15.
